// File: rtl/isp_bayer_pkg.sv
// Shared Bayer/ISP definitions: CFA order codes, channel selection, bayer word layout.
package isp_bayer_pkg;

  localparam int unsigned PIX_W      = 8;
  localparam int unsigned RGB_W      = 3 * PIX_W;
  localparam int unsigned BAYER_W    = 16;
  localparam int unsigned SAMPLE_LSB = 4;
  localparam int unsigned CFA_W      = 2;

  localparam logic [CFA_W-1:0] CFA_GRBG = 2'd0;
  localparam logic [CFA_W-1:0] CFA_RGGB = 2'd1;
  localparam logic [CFA_W-1:0] CFA_BGGR = 2'd2;
  localparam logic [CFA_W-1:0] CFA_GBRG = 2'd3;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } chan_e;

  // Channel at (line phase, pixel phase). Every order is GRBG with the pixel
  // and/or line phase inverted, so the orders reduce to two flip bits.
  function automatic chan_e cfa_channel(input logic            odd_line,
                                        input logic            odd_pix,
                                        input logic [CFA_W-1:0] cfa);
    logic flip_pix;
    logic flip_line;
    logic l;
    logic p;
    flip_pix  = 1'b0;
    flip_line = 1'b0;
    case (cfa)
      CFA_RGGB: flip_pix = 1'b1;
      CFA_BGGR: flip_line = 1'b1;
      CFA_GBRG: begin
        flip_pix  = 1'b1;
        flip_line = 1'b1;
      end
      default: ;
    endcase
    l = odd_line ^ flip_line;
    p = odd_pix ^ flip_pix;
    if (l == p)
      return CH_G;
    else if (!l)
      return CH_R;
    else
      return CH_B;
  endfunction

endpackage

// File: rtl/rgb888_to_bayer_sync_edge_det.sv
// Registers a level and flags its rising/falling edges against the registered copy.
module sync_edge_det (
  input  logic pclk,
  input  logic rst_n,
  input  logic i_lvl,
  output logic o_lvl_q,
  output logic o_rise_c,
  output logic o_fall_c
);

  logic r_lvl;

  // One-cycle delayed copy of the level.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) r_lvl <= 1'b0;
    else        r_lvl <= i_lvl;
  end

  assign o_lvl_q  = r_lvl;
  assign o_rise_c = i_lvl & ~r_lvl;
  assign o_fall_c = ~i_lvl & r_lvl;

endmodule

// File: rtl/rgb888_to_bayer.sv
// RGB888 -> 16-bit Bayer re-mosaic with sensor timing and frame geometry capture.
// Optional build macro RGB2BAYER_CFA_SEL_EN: cfa_sel picks the CFA order per frame;
// otherwise the order is fixed to GRBG.
module rgb888_to_bayer
  import isp_bayer_pkg::*;
#(
  parameter int unsigned CNT_W = 12
) (
  input  logic               pclk,
  input  logic               rst_n,
  input  logic               in_href,
  input  logic               in_vsync,
  input  logic [RGB_W-1:0]   rgb888,
  input  logic [CFA_W-1:0]   cfa_sel,
  output logic               out_href,
  output logic               out_vsync,
  output logic [BAYER_W-1:0] bayer_data,
  output logic [CNT_W-1:0]   line_len,
  output logic [CNT_W-1:0]   frame_lines,
  output logic               len_err,
  output logic               frame_done
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic               w_href_q;
  logic               w_href_rise_unused;
  logic               w_href_fall;
  logic               w_vs_q;
  logic               w_vs_rise;
  logic               w_vs_fall_unused;
  logic [CFA_W-1:0]   w_cfa;
  chan_e              w_ch;
  logic [PIX_W-1:0]   w_sample;
  logic [BAYER_W-1:0] w_word;
  logic               w_len_mis;

  logic               r_odd_pix;
  logic               r_odd_line;
  logic [BAYER_W-1:0] r_bayer;
  logic [CNT_W-1:0]   r_pix_cnt;
  logic [CNT_W-1:0]   r_line_cnt;
  logic [CNT_W-1:0]   r_ref_len;
  logic               r_len_err;
  logic [CNT_W-1:0]   r_line_len;
  logic [CNT_W-1:0]   r_frame_lines;
  logic               r_frame_done;

  sync_edge_det u_href_det (
    .pclk     (pclk),
    .rst_n    (rst_n),
    .i_lvl    (in_href),
    .o_lvl_q  (w_href_q),
    .o_rise_c (w_href_rise_unused),
    .o_fall_c (w_href_fall)
  );

  sync_edge_det u_vsync_det (
    .pclk     (pclk),
    .rst_n    (rst_n),
    .i_lvl    (in_vsync),
    .o_lvl_q  (w_vs_q),
    .o_rise_c (w_vs_rise),
    .o_fall_c (w_vs_fall_unused)
  );

`ifdef RGB2BAYER_CFA_SEL_EN
  logic [CFA_W-1:0] r_cfa;

  // CFA order latched at frame start and held for the frame.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n)         r_cfa <= CFA_GRBG;
    else if (w_vs_rise) r_cfa <= cfa_sel;
  end

  assign w_cfa = r_cfa;
`else
  logic w_cfa_sel_unused;
  assign w_cfa_sel_unused = ^cfa_sel;
  assign w_cfa            = CFA_GRBG;
`endif

  // Pick the colour sample for the current pixel/line phase.
  always_comb begin
    w_ch     = cfa_channel(r_odd_line, r_odd_pix, w_cfa);
    w_sample = rgb888[PIX_W-1:0];
    case (w_ch)
      CH_R:    w_sample = rgb888[3*PIX_W-1:2*PIX_W];
      CH_G:    w_sample = rgb888[2*PIX_W-1:PIX_W];
      default: w_sample = rgb888[PIX_W-1:0];
    endcase
    w_word = BAYER_W'(w_sample) << SAMPLE_LSB;
  end

  // Mosaic phase tracking and the registered bayer word.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_odd_pix  <= 1'b0;
      r_odd_line <= 1'b0;
      r_bayer    <= '0;
    end else begin
      r_odd_pix <= in_href ? ~r_odd_pix : 1'b0;
      if (in_vsync)         r_odd_line <= 1'b0;
      else if (w_href_fall) r_odd_line <= ~r_odd_line;
      r_bayer <= in_href ? w_word : '0;
    end
  end

  // A completed line (after the first of the frame) whose length differs from the first.
  assign w_len_mis = w_href_fall && (r_line_cnt != '0) && (r_pix_cnt != r_ref_len);

  // Saturating pixel/line counters, reference line length and sticky length error.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_cnt  <= '0;
      r_line_cnt <= '0;
      r_ref_len  <= '0;
      r_len_err  <= 1'b0;
    end else begin
      if (w_href_fall)
        r_pix_cnt <= '0;
      else if (in_href && (r_pix_cnt != CNT_MAX))
        r_pix_cnt <= r_pix_cnt + CNT_W'(1);

      if (w_vs_rise)
        r_line_cnt <= '0;
      else if (w_href_fall && (r_line_cnt != CNT_MAX))
        r_line_cnt <= r_line_cnt + CNT_W'(1);

      if (w_href_fall && (r_line_cnt == '0))
        r_ref_len <= r_pix_cnt;

      if (w_len_mis)      r_len_err <= 1'b1;
      else if (w_vs_rise) r_len_err <= 1'b0;
    end
  end

  // Previous-frame geometry snapshot and frame-start pulse.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_line_len    <= '0;
      r_frame_lines <= '0;
      r_frame_done  <= 1'b0;
    end else begin
      r_frame_done <= w_vs_rise;
      if (w_vs_rise) begin
        r_line_len    <= r_ref_len;
        r_frame_lines <= r_line_cnt;
      end
    end
  end

  assign out_href    = w_href_q;
  assign out_vsync   = w_vs_q;
  assign bayer_data  = r_bayer;
  assign line_len    = r_line_len;
  assign frame_lines = r_frame_lines;
  assign len_err     = r_len_err;
  assign frame_done  = r_frame_done;

endmodule
